// File: rtl/cpu_pa_latch.sv
// Physical address latch: combines the page offset with either the bypass PPN or a
// translated PPN and holds the result until memory accepts it; times out stalled translations.
module cpu_pa_latch #(
   parameter int unsigned TMO_CYCLES = 12,
   localparam int unsigned OffW = 10,
   localparam int unsigned PpnW = 14,
   localparam int unsigned PaW  = OffW + PpnW,
   localparam int unsigned CntW = 4
) (
   input  logic            sysclk,
   input  logic            sys_rst,
   input  logic            LAPA_n,
   input  logic [OffW-1:0] LA_9_0,
   input  logic [PpnW-1:0] PPN_23_10,
   input  logic            PPN_VALID,
   input  logic            ACC_REQ,
   input  logic            MEM_ACK,
   output logic [PaW-1:0]  PA_23_0,
   output logic            PA_VALID,
   output logic            BUSY,
   output logic            PFAULT
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XLAT = 2'd1,
      HOLD = 2'd2
   } stateT;

   localparam logic [CntW-1:0] TmoLast = CntW'(TMO_CYCLES - 1);

   stateT           state;
   stateT           stateNext;
   logic [CntW-1:0] tmoCnt;
   logic [CntW-1:0] tmoCntNext;
   logic [PaW-1:0]  paNext;
   logic            paValidNext;
   logic            busyNext;
   logic            pfaultNext;
   logic            accept;

   // State and registered outputs
   always_ff @(posedge sysclk or posedge sys_rst) begin
      if (sys_rst) begin
         state    <= IDLE;
         tmoCnt   <= '0;
         PA_23_0  <= '0;
         PA_VALID <= 1'b0;
         BUSY     <= 1'b0;
         PFAULT   <= 1'b0;
      end else begin
         state    <= stateNext;
         tmoCnt   <= tmoCntNext;
         PA_23_0  <= paNext;
         PA_VALID <= paValidNext;
         BUSY     <= busyNext;
         PFAULT   <= pfaultNext;
      end
   end

   // Next-state, address capture and timeout
   always_comb begin
      stateNext  = state;
      tmoCntNext = tmoCnt;
      paNext     = PA_23_0;
      pfaultNext = 1'b0;
      accept     = 1'b0;

      case (state)
         IDLE: begin
            accept = ACC_REQ;
         end
         XLAT: begin
            // A translation arriving in the timeout cycle wins over the fault
            if (PPN_VALID) begin
               paNext[PaW-1:OffW] = PPN_23_10;
               stateNext          = HOLD;
            end else if (tmoCnt == TmoLast) begin
               pfaultNext = 1'b1;
               stateNext  = IDLE;
            end else begin
               tmoCntNext = tmoCnt + CntW'(1);
            end
         end
         HOLD: begin
            if (MEM_ACK) begin
               if (ACC_REQ) begin
                  accept = 1'b1;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase

      // New access: offset always captured; bypass also takes the PPN directly
      if (accept) begin
         paNext[OffW-1:0] = LA_9_0;
         if (!LAPA_n) begin
            paNext[PaW-1:OffW] = PPN_23_10;
            stateNext          = HOLD;
         end else begin
            tmoCntNext = '0;
            stateNext  = XLAT;
         end
      end

      paValidNext = (stateNext == HOLD);
      busyNext    = (stateNext != IDLE);
   end

endmodule

// File: tb/tb_cpu_pa_latch.sv
// Scoreboard bench for cpu_pa_latch: a behavioural model predicts each cycle's outputs,
// which are queued at drive time and compared after the clock edge.
module tb_cpu_pa_latch;

   localparam int unsigned Tmo = 12;

   logic        sysclk;
   logic        sys_rst;
   logic        LAPA_n;
   logic [9:0]  LA_9_0;
   logic [13:0] PPN_23_10;
   logic        PPN_VALID;
   logic        ACC_REQ;
   logic        MEM_ACK;
   logic [23:0] PA_23_0;
   logic        PA_VALID;
   logic        BUSY;
   logic        PFAULT;

   cpu_pa_latch #(.TMO_CYCLES(Tmo)) dut (
      .sysclk   (sysclk),
      .sys_rst  (sys_rst),
      .LAPA_n   (LAPA_n),
      .LA_9_0   (LA_9_0),
      .PPN_23_10(PPN_23_10),
      .PPN_VALID(PPN_VALID),
      .ACC_REQ  (ACC_REQ),
      .MEM_ACK  (MEM_ACK),
      .PA_23_0  (PA_23_0),
      .PA_VALID (PA_VALID),
      .BUSY     (BUSY),
      .PFAULT   (PFAULT)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   typedef struct packed {
      logic [23:0] pa;
      logic        paValid;
      logic        busy;
      logic        pfault;
   } expT;

   expT expQ[$];
   int  nCompared = 0;
   int  nMismatched = 0;

   // Model: 0 = idle, 1 = waiting for translation, 2 = address held
   int          mState = 0;
   int          mWaited = 0;
   logic [23:0] mPa = '0;
   logic        mPfault = 1'b0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mState  = 0;
      mWaited = 0;
      mPa     = '0;
      mPfault = 1'b0;
   endtask

   task automatic modelStart();
      mPa[9:0] = LA_9_0;
      if (LAPA_n == 1'b0) begin
         mPa[23:10] = PPN_23_10;
         mState     = 2;
      end else begin
         mWaited = 0;
         mState  = 1;
      end
   endtask

   task automatic modelStep();
      mPfault = 1'b0;
      if (mState == 0) begin
         if (ACC_REQ) modelStart();
      end else if (mState == 1) begin
         if (PPN_VALID) begin
            mPa[23:10] = PPN_23_10;
            mState     = 2;
         end else if (mWaited + 1 == Tmo) begin
            mPfault = 1'b1;
            mState  = 0;
         end else begin
            mWaited++;
         end
      end else begin
         if (MEM_ACK) begin
            if (ACC_REQ) modelStart();
            else mState = 0;
         end
      end
   endtask

   task automatic drive(input logic acc, input logic lapa, input logic [9:0] la,
                        input logic [13:0] ppn, input logic pv, input logic ack);
      ACC_REQ   = acc;
      LAPA_n    = lapa;
      LA_9_0    = la;
      PPN_23_10 = ppn;
      PPN_VALID = pv;
      MEM_ACK   = ack;
   endtask

   // Predict, push, clock, then pop and compare at the falling edge
   task automatic runCycle();
      expT e;
      modelStep();
      e.pa      = mPa;
      e.paValid = (mState == 2);
      e.busy    = (mState != 0);
      e.pfault  = mPfault;
      expQ.push_back(e);
      @(posedge sysclk);
      @(negedge sysclk);
      e = expQ.pop_front();
      checkVal("pa", 32'(PA_23_0), 32'(e.pa));
      checkVal("paValid", 32'(PA_VALID), 32'(e.paValid));
      checkVal("busy", 32'(BUSY), 32'(e.busy));
      checkVal("pfault", 32'(PFAULT), 32'(e.pfault));
      checkVal("pfaultValidExcl", 32'(PFAULT & PA_VALID), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkVal({tag, "Pa"}, 32'(PA_23_0), 32'h0);
      checkVal({tag, "Valid"}, 32'(PA_VALID), 32'h0);
      checkVal({tag, "Busy"}, 32'(BUSY), 32'h0);
      checkVal({tag, "Pfault"}, 32'(PFAULT), 32'h0);
   endtask

   initial begin
      int lat;
      sys_rst = 1'b1;
      drive(1'b0, 1'b0, 10'h0, 14'h0, 1'b0, 1'b0);
      repeat (2) @(negedge sysclk);
      checkAllZero("reset");
      modelReset();
      sys_rst = 1'b0;

      // Bypass access, one hold cycle, then memory accepts
      drive(1'b1, 1'b0, 10'h155, 14'h2A5C, 1'b0, 1'b0);
      runCycle();
      checkVal("bypassPa", 32'(PA_23_0), 32'hA97155);
      checkVal("bypassValid", 32'(PA_VALID), 32'h1);
      checkVal("bypassBusy", 32'(BUSY), 32'h1);
      drive(1'b0, 1'b1, 10'h0AA, 14'h1111, 1'b1, 1'b0);
      runCycle();
      drive(1'b0, 1'b0, 10'h000, 14'h0000, 1'b0, 1'b1);
      runCycle();
      checkVal("bypassDoneValid", 32'(PA_VALID), 32'h0);
      checkVal("bypassDoneBusy", 32'(BUSY), 32'h0);
      checkVal("bypassKeepPa", 32'(PA_23_0), 32'hA97155);

      // Paged access, translation on the third XLAT cycle; stray request ignored
      drive(1'b1, 1'b1, 10'h3FF, 14'h2222, 1'b0, 1'b0);
      runCycle();
      drive(1'b1, 1'b0, 10'h001, 14'h3333, 1'b0, 1'b1);
      runCycle();
      drive(1'b0, 1'b0, 10'h002, 14'h0444, 1'b0, 1'b0);
      runCycle();
      drive(1'b0, 1'b1, 10'h003, 14'h0011, 1'b1, 1'b0);
      runCycle();
      checkVal("pagedPa", 32'(PA_23_0), 32'h0047FF);
      checkVal("pagedValid", 32'(PA_VALID), 32'h1);
      drive(1'b1, 1'b0, 10'h123, 14'h3ABC, 1'b1, 1'b0);
      runCycle();
      checkVal("holdIgnoreReq", 32'(PA_23_0), 32'h0047FF);
      drive(1'b0, 1'b0, 10'h000, 14'h0000, 1'b0, 1'b1);
      runCycle();

      // Timeout: fault pulse twelve cycles after entering XLAT
      drive(1'b1, 1'b1, 10'h2AA, 14'h1555, 1'b0, 1'b0);
      runCycle();
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         drive(1'b0, k[0], 10'(k), 14'(k * 7), 1'b0, 1'b1);
         runCycle();
         if (PFAULT) begin
            lat = k;
            break;
         end
      end
      checkVal("tmoLatency", 32'(lat), 32'(Tmo));
      checkVal("tmoValid", 32'(PA_VALID), 32'h0);
      checkVal("tmoPa", 32'(PA_23_0), 32'h0046AA);
      drive(1'b0, 1'b0, 10'h000, 14'h0000, 1'b0, 1'b0);
      runCycle();
      checkVal("tmoPulseEnd", 32'(PFAULT), 32'h0);

      // Translation in the timeout cycle wins, then back-to-back bypass
      drive(1'b1, 1'b1, 10'h001, 14'h0000, 1'b0, 1'b0);
      runCycle();
      for (int k = 0; k < int'(Tmo) - 1; k++) begin
         drive(1'b0, 1'b1, 10'h000, 14'h0000, 1'b0, 1'b0);
         runCycle();
      end
      drive(1'b0, 1'b1, 10'h000, 14'h3FFF, 1'b1, 1'b0);
      runCycle();
      checkVal("edgePfault", 32'(PFAULT), 32'h0);
      checkVal("edgePa", 32'(PA_23_0), 32'hFFFC01);
      checkVal("edgeValid", 32'(PA_VALID), 32'h1);
      drive(1'b1, 1'b0, 10'h0AB, 14'h1234, 1'b0, 1'b1);
      runCycle();
      checkVal("b2bPa", 32'(PA_23_0), 32'h48D0AB);
      checkVal("b2bValid", 32'(PA_VALID), 32'h1);
      drive(1'b0, 1'b0, 10'h000, 14'h0000, 1'b0, 1'b1);
      runCycle();

      // Reset in the middle of a translation
      drive(1'b1, 1'b1, 10'h155, 14'h0000, 1'b0, 1'b0);
      runCycle();
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b1, 10'h000, 14'h0000, 1'b0, 1'b0);
         runCycle();
      end
      sys_rst = 1'b1;
      #1;
      checkAllZero("rstAsync");
      modelReset();
      @(posedge sysclk);
      @(negedge sysclk);
      checkAllZero("rstHeld");
      sys_rst = 1'b0;
      drive(1'b1, 1'b0, 10'h010, 14'h0100, 1'b0, 1'b0);
      runCycle();
      checkVal("rstFirstReq", 32'(PA_23_0), 32'h040010);
      drive(1'b0, 1'b0, 10'h000, 14'h0000, 1'b0, 1'b1);
      runCycle();

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 9) < 3), 1'($urandom), 10'($urandom), 14'($urandom),
               ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 4));
         runCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
